// File: rtl/debug_sequencer.sv
// Debug sequencer: turns a host byte stream into pipeline control.
// It loads instruction memory, runs or single-steps the core, pulses the
// PC reset, and dumps the register file plus the first data-memory words
// back to the host as a byte stream, MSB first.
module debug_sequencer #(
   parameter int NB_REG      = 32,
   parameter int NB_BYTE     = 8,
   parameter int N_MEM_WORDS = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   input  logic               i_halt,
   input  logic [NB_REG-1:0]  i_dunit_reg,
   input  logic [NB_REG-1:0]  i_dunit_mem_data,
   output logic               o_dunit_clk_en,
   output logic               o_dunit_reset_pc,
   output logic               o_dunit_w_mem,
   output logic [NB_REG-1:0]  o_dunit_addr,
   output logic [NB_REG-1:0]  o_dunit_data_if,
   output logic               o_busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_CNT,
      S_LOAD_BYTE,
      S_LOAD_WR,
      S_RUN,
      S_STEP,
      S_DUMP_ADDR,
      S_DUMP_LATCH,
      S_DUMP_SEND,
      S_PCRST
   } state_t;

   localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
   localparam logic [NB_BYTE-1:0] CMD_CONT  = NB_BYTE'(8'h43);
   localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
   localparam logic [NB_BYTE-1:0] CMD_PCRST = NB_BYTE'(8'h52);

   // Dump index: registers occupy 0..31, memory words follow.
   localparam logic [5:0] DUMP_REGS = 6'd32;
   localparam logic [5:0] DUMP_LAST = 6'(32 + N_MEM_WORDS - 1);

   state_t              state_q, state_d;
   logic                halted_q, halted_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          word_q, word_d;
   logic [1:0]          byte_q, byte_d;
   logic [5:0]          dump_q, dump_d;
   logic [NB_REG-1:0]   shift_q, shift_d;
   logic                clk_en_q, clk_en_d;
   logic                w_mem_q, w_mem_d;
   logic                reset_pc_q, reset_pc_d;
   logic [NB_REG-1:0]   addr_q, addr_d;
   logic [NB_REG-1:0]   data_if_q, data_if_d;
   logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic [NB_REG-1:0]   latch_word;

   // Address presented for dump entry idx: register number, or byte address of a memory word.
   function automatic logic [NB_REG-1:0] dump_addr(input logic [5:0] idx);
      logic [7:0] mem_byte_addr;
      mem_byte_addr = {idx - DUMP_REGS, 2'b00};
      if (idx < DUMP_REGS) begin
         return NB_REG'(idx);
      end
      return NB_REG'(mem_byte_addr);
   endfunction

   assign latch_word = (dump_q < DUMP_REGS) ? i_dunit_reg : i_dunit_mem_data;

   // Next-state and registered-output logic; pulses default low, data holds.
   always_comb begin
      state_d    = state_q;
      halted_d   = halted_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      byte_d     = byte_q;
      dump_d     = dump_q;
      shift_d    = shift_q;
      clk_en_d   = 1'b0;
      w_mem_d    = 1'b0;
      reset_pc_d = 1'b0;
      addr_d     = addr_q;
      data_if_d  = data_if_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_rx_valid) begin
               if (i_rx_data == CMD_LOAD) begin
                  state_d = S_LOAD_CNT;
               end else if ((i_rx_data == CMD_CONT) || (i_rx_data == CMD_STEP)) begin
                  if (halted_q) begin
                     // Core already halted: nothing left to execute, report only.
                     dump_d  = '0;
                     byte_d  = '0;
                     addr_d  = dump_addr(6'd0);
                     state_d = S_DUMP_ADDR;
                  end else begin
                     clk_en_d = 1'b1;
                     state_d  = (i_rx_data == CMD_CONT) ? S_RUN : S_STEP;
                  end
               end else if (i_rx_data == CMD_PCRST) begin
                  reset_pc_d = 1'b1;
                  state_d    = S_PCRST;
               end
            end
         end
         S_LOAD_CNT: begin
            if (i_rx_valid) begin
               cnt_d  = 8'(i_rx_data);
               word_d = '0;
               byte_d = '0;
               if (i_rx_data == '0) begin
                  reset_pc_d = 1'b1;
                  state_d    = S_PCRST;
               end else begin
                  state_d = S_LOAD_BYTE;
               end
            end
         end
         S_LOAD_BYTE: begin
            if (i_rx_valid) begin
               data_if_d = {data_if_q[NB_REG-NB_BYTE-1:0], i_rx_data};
               byte_d    = byte_q + 2'd1;
               if (byte_q == 2'd3) begin
                  w_mem_d = 1'b1;
                  addr_d  = NB_REG'({word_q, 2'b00});
                  state_d = S_LOAD_WR;
               end
            end
         end
         S_LOAD_WR: begin
            if (word_q == cnt_q - 8'd1) begin
               reset_pc_d = 1'b1;
               state_d    = S_PCRST;
            end else begin
               word_d  = word_q + 8'd1;
               state_d = S_LOAD_BYTE;
            end
         end
         S_RUN: begin
            if (i_halt) begin
               halted_d = 1'b1;
               dump_d   = '0;
               byte_d   = '0;
               addr_d   = dump_addr(6'd0);
               state_d  = S_DUMP_ADDR;
            end else begin
               clk_en_d = 1'b1;
            end
         end
         S_STEP: begin
            if (i_halt) begin
               halted_d = 1'b1;
            end
            dump_d  = '0;
            byte_d  = '0;
            addr_d  = dump_addr(6'd0);
            state_d = S_DUMP_ADDR;
         end
         S_DUMP_ADDR: begin
            // Give the register file / memory a cycle to respond to the new address.
            state_d = S_DUMP_LATCH;
         end
         S_DUMP_LATCH: begin
            shift_d    = latch_word;
            tx_data_d  = latch_word[NB_REG-1 -: NB_BYTE];
            tx_valid_d = 1'b1;
            byte_d     = '0;
            state_d    = S_DUMP_SEND;
         end
         S_DUMP_SEND: begin
            if (tx_valid_q && i_tx_ready) begin
               byte_d = byte_q + 2'd1;
               if (byte_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  if (dump_q == DUMP_LAST) begin
                     state_d = S_IDLE;
                  end else begin
                     dump_d  = dump_q + 6'd1;
                     addr_d  = dump_addr(dump_q + 6'd1);
                     state_d = S_DUMP_ADDR;
                  end
               end else begin
                  shift_d   = shift_q << NB_BYTE;
                  tx_data_d = shift_q[NB_REG-NB_BYTE-1 -: NB_BYTE];
               end
            end
         end
         S_PCRST: begin
            halted_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, counters and all outputs; reset clears everything asynchronously.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
         word_q     <= '0;
         byte_q     <= '0;
         dump_q     <= '0;
         shift_q    <= '0;
         clk_en_q   <= 1'b0;
         w_mem_q    <= 1'b0;
         reset_pc_q <= 1'b0;
         addr_q     <= '0;
         data_if_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         halted_q   <= halted_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         byte_q     <= byte_d;
         dump_q     <= dump_d;
         shift_q    <= shift_d;
         clk_en_q   <= clk_en_d;
         w_mem_q    <= w_mem_d;
         reset_pc_q <= reset_pc_d;
         addr_q     <= addr_d;
         data_if_q  <= data_if_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign o_tx_data        = tx_data_q;
   assign o_tx_valid       = tx_valid_q;
   assign o_dunit_clk_en   = clk_en_q;
   assign o_dunit_reset_pc = reset_pc_q;
   assign o_dunit_w_mem    = w_mem_q;
   assign o_dunit_addr     = addr_q;
   assign o_dunit_data_if  = data_if_q;
   assign o_busy           = busy_q;

endmodule
